// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, pc_src encodings, fetch FSM states.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
    localparam logic [1:0] PC_SRC_JUMP = 2'b01;
    localparam logic [1:0] PC_SRC_JR   = 2'b10;

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ERR   = 3'd4
    } fetch_state_e;

    // Sign-extended, word-scaled branch displacement.
    function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jr > j/jal > taken branch > sequential.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic [1:0]  pc_src,
    input  logic        branch,
    input  logic        cond_zero,
    input  logic        zero,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc
);

    // Opcode bits are decoded upstream; only the immediate fields matter here.
    logic w_unused_op;
    assign w_unused_op = ^instr[31:26];

    // Priority select; reserved pc_src=11 falls through to the branch/sequential path.
    always_comb begin
        next_pc = pc_plus4;
        if (pc_src == PC_SRC_JR) begin
            next_pc = jr_target;
        end else if (pc_src == PC_SRC_JUMP) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && (zero == cond_zero)) begin
            next_pc = pc_plus4 + branch_offset(instr[15:0]);
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch / PC sequencer: one outstanding imem read, valid/ready to decode.
module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic [5:0]       opcode,
    output logic [5:0]       funct,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic [1:0]       pc_src,
    input  logic             branch,
    input  logic             cond_zero,
    input  logic             zero,
    input  logic [31:0]      jr_target,
    output logic             addr_err,
    output logic [CNT_W-1:0] retired
);

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [CNT_W-1:0] r_retired;
    logic             r_imem_req;
    logic             r_instr_valid;
    logic             r_addr_err;
    logic             w_capture;
    logic             w_accept;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_next_pc;

    assign w_pc_plus4 = r_pc + 32'd4;

    next_pc_calc u_next_pc (
        .pc_plus4  (w_pc_plus4),
        .instr     (r_instr),
        .pc_src    (pc_src),
        .branch    (branch),
        .cond_zero (cond_zero),
        .zero      (zero),
        .jr_target (jr_target),
        .next_pc   (w_next_pc)
    );

    // Next-state decode plus capture/accept strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_RST:   w_state_nxt = ST_FETCH;
            ST_FETCH: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (imem_rvalid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (w_next_pc[1:0] != 2'b00) ? ST_ERR : ST_FETCH;
                end
            end
            ST_ERR:   w_state_nxt = ST_ERR;
            default:  w_state_nxt = ST_RST;
        endcase
    end

    // State register with registered per-state output flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RST;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_addr_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_imem_req    <= (w_state_nxt == ST_FETCH);
            r_instr_valid <= (w_state_nxt == ST_HOLD);
            r_addr_err    <= (w_state_nxt == ST_ERR);
        end
    end

    // Datapath: instruction capture, PC update and retire count on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_instr   <= 32'h0000_0000;
            r_retired <= '0;
        end else begin
            if (w_capture) begin
                r_instr <= imem_rdata;
            end
            if (w_accept) begin
                r_pc      <= w_next_pc;
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign funct       = r_instr[5:0];
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign addr_err    = r_addr_err;
    assign retired     = r_retired;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: transaction-level model plus directed fetch/redirect scenarios.
module tb_ifetch_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        rst_n = 1'b0;
    logic        imem_req, imem_rvalid = 1'b0, instr_valid, instr_ready = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'h0, instr, pc, pc_plus4, jr_target = 32'h0;
    logic [5:0]  opcode, funct;
    logic [1:0]  pc_src = 2'b00;
    logic        branch = 1'b0, cond_zero = 1'b0, zero = 1'b0, addr_err;
    logic [31:0] retired;

    // Instance B: pc near the top of memory, 2-bit counter to exercise wrap
    logic        b_rst_n = 1'b0;
    logic        b_req, b_rvalid = 1'b0, b_valid, b_ready = 1'b0, b_err;
    logic [31:0] b_addr, b_rdata = 32'h0, b_instr, b_pc, b_pc_plus4;
    logic [5:0]  b_opcode, b_funct;
    logic [1:0]  b_retired;

    int errors = 0;
    int checks = 0;

    ifetch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .opcode(opcode), .funct(funct),
        .pc(pc), .pc_plus4(pc_plus4), .pc_src(pc_src), .branch(branch),
        .cond_zero(cond_zero), .zero(zero), .jr_target(jr_target),
        .addr_err(addr_err), .retired(retired)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .imem_req(b_req), .imem_addr(b_addr),
        .imem_rvalid(b_rvalid), .imem_rdata(b_rdata), .instr_valid(b_valid),
        .instr_ready(b_ready), .instr(b_instr), .opcode(b_opcode), .funct(b_funct),
        .pc(b_pc), .pc_plus4(b_pc_plus4), .pc_src(2'b00), .branch(1'b0),
        .cond_zero(1'b0), .zero(1'b0), .jr_target(32'h0),
        .addr_err(b_err), .retired(b_retired)
    );

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    // Architectural next-PC rule, using signed integer arithmetic for the displacement.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] iw,
                                               input logic [1:0] src, input logic br,
                                               input logic cz, input logic z,
                                               input logic [31:0] jt);
        logic [31:0] seq;
        int          off;
        seq = cur + 32'd4;
        off = int'($signed(iw[15:0])) * 4;
        if (src == 2'b10) return jt;
        if (src == 2'b01) return {seq[31:28], iw[25:0], 2'b00};
        if (br && (z == cz)) return seq + 32'(off);
        return seq;
    endfunction

    // Model state: expected pc, last delivered word, retire count, error flag.
    logic [31:0] m_pc, m_instr, m_ret, m_nxt;
    logic        m_err, m_wait, m_prev_req;

    // Every-cycle compare of instance A against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_pc = 32'h0; m_instr = 32'h0; m_ret = 32'h0;
            m_err = 1'b0; m_wait = 1'b0; m_prev_req = 1'b0;
            chk1("rst_req", imem_req, 1'b0);
            chk1("rst_valid", instr_valid, 1'b0);
            chk1("rst_err", addr_err, 1'b0);
            chk32("rst_pc", pc, 32'h0);
            chk32("rst_retired", retired, 32'h0);
            chk32("rst_instr", instr, 32'h0);
        end else begin
            chk1("m_err", addr_err, m_err);
            chk32("m_retired", retired, m_ret);
            if (imem_req) begin
                chk32("m_addr", imem_addr, m_pc);
                chk1("m_req_single", m_prev_req, 1'b0);
                chk1("m_req_novalid", instr_valid, 1'b0);
                m_wait = 1'b1;
            end
            if (m_err) begin
                chk1("m_err_noreq", imem_req, 1'b0);
                chk1("m_err_novalid", instr_valid, 1'b0);
                chk32("m_err_pc", pc, m_pc);
            end
            if (instr_valid) begin
                chk32("m_instr", instr, m_instr);
                chk32("m_pc", pc, m_pc);
                chk32("m_pc_plus4", pc_plus4, m_pc + 32'd4);
                chk32("m_opcode", 32'(opcode), 32'(m_instr[31:26]));
                chk32("m_funct", 32'(funct), 32'(m_instr[5:0]));
            end
            if (m_wait && imem_rvalid && !imem_req) begin
                m_instr = imem_rdata;
                m_wait  = 1'b0;
            end
            if (instr_valid && instr_ready) begin
                m_nxt = model_next(m_pc, m_instr, pc_src, branch, cond_zero, zero, jr_target);
                m_pc  = m_nxt;
                m_ret = m_ret + 32'd1;
                m_err = (m_nxt[1:0] != 2'b00);
            end
            m_prev_req = imem_req;
        end
    end

    // Wait for a request, check its address, then return rvalid after `delay` cycles.
    task automatic serve(input logic [31:0] word, input int delay, input logic [31:0] exp_addr);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            timeout("serve_req");
            return;
        end
        chk32("fetch_addr", imem_addr, exp_addr);
        repeat (delay) @(posedge clk);
        #1 imem_rdata = word; imem_rvalid = 1'b1;
        @(posedge clk);
        #1 imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    endtask

    // Accept the held instruction after `stall` idle cycles; scramble controls otherwise.
    task automatic accept(input logic [1:0] src, input logic br, input logic cz,
                          input logic z, input logic [31:0] jt, input int stall);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            timeout("accept_valid");
            return;
        end
        repeat (stall) @(posedge clk);
        @(posedge clk);
        #1 pc_src = src; branch = br; cond_zero = cz; zero = z; jr_target = jt;
        instr_ready = 1'b1;
        @(posedge clk);
        #1 instr_ready = 1'b0;
        pc_src = 2'b10; jr_target = 32'h0000_0003; branch = 1'b1; cond_zero = ~z; zero = z;
    endtask

    localparam logic [31:0] W_JR  = 32'h03E0_0008;
    localparam logic [31:0] W_NOP = 32'h0000_0000;

    logic [31:0] b_exp_addr [4] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
    logic [1:0]  b_exp_ret  [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        bit ok;
        pc_src = 2'b10; jr_target = 32'h0000_0003;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // First fetch: request after reset, rvalid one cycle later, valid on cycle 3
        @(posedge clk); #1;
        chk1("t1_req", imem_req, 1'b1);
        chk32("t1_addr", imem_addr, 32'h0);
        chk1("t1_valid_c1", instr_valid, 1'b0);
        @(posedge clk); #1;
        chk1("t1_req_c2", imem_req, 1'b0);
        imem_rdata = 32'h2408_0005; imem_rvalid = 1'b1;
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        chk1("t1_valid_c3", instr_valid, 1'b1);
        chk32("t1_opcode", 32'(opcode), 32'h0000_0009);
        chk32("t1_pc_plus4", pc_plus4, 32'h4);
        chk32("t1_instr", instr, 32'h2408_0005);
        // Spurious rvalid while holding must not disturb the held word
        @(posedge clk); #1 imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        @(posedge clk); #1 imem_rvalid = 1'b0;
        chk32("t1_spurious", instr, 32'h2408_0005);
        accept(2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 3);

        // Second sequential fetch with slow memory
        serve(32'h0109_4020, 5, 32'h4);
        accept(2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 2);
        chk32("t2_retired", retired, 32'd2);

        // Branches at 0x10
        serve(W_JR, 1, 32'h8);
        accept(2'b10, 1'b0, 1'b0, 1'b0, 32'h10, 0);
        serve(32'h1000_FFFC, 1, 32'h10);
        accept(2'b00, 1'b1, 1'b1, 1'b1, 32'h0, 1);
        serve(W_JR, 1, 32'h4);
        accept(2'b10, 1'b0, 1'b0, 1'b0, 32'h10, 0);
        serve(32'h1000_FFFC, 1, 32'h10);
        accept(2'b00, 1'b1, 1'b1, 1'b0, 32'h0, 0);
        serve(W_NOP, 1, 32'h14);
        accept(2'b10, 1'b0, 1'b0, 1'b0, 32'h10, 0);
        serve(32'h1400_FFFC, 1, 32'h10);
        accept(2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 0);

        // j and jr
        serve(W_JR, 1, 32'h4);
        accept(2'b10, 1'b0, 1'b0, 1'b0, 32'h1000_0000, 0);
        serve(32'h0800_0040, 1, 32'h1000_0000);
        accept(2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        serve(W_JR, 1, 32'h1000_0100);
        accept(2'b10, 1'b0, 1'b0, 1'b0, 32'h200, 0);

        // Misaligned jr target halts fetch
        serve(W_JR, 1, 32'h200);
        accept(2'b10, 1'b0, 1'b0, 1'b0, 32'h202, 0);
        instr_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 instr_ready = 1'b0;
        chk1("err_flag", addr_err, 1'b1);
        chk1("err_valid", instr_valid, 1'b0);
        chk1("err_req", imem_req, 1'b0);
        chk32("err_pc", pc, 32'h202);
        chk32("err_retired", retired, 32'd12);

        // Async reset clears the error and restarts at RESET_PC
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk1("arst_err", addr_err, 1'b0);
        chk32("arst_pc", pc, 32'h0);
        @(negedge clk); #2 rst_n = 1'b1;
        serve(W_NOP, 1, 32'h0);
        accept(2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 0);

        // Reset in the middle of an outstanding read
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_req_mid");
        chk32("mid_addr", imem_addr, 32'h4);
        @(posedge clk); #1 rst_n = 1'b0;
        #1 chk32("mid_rst_pc", pc, 32'h0);
        @(negedge clk); #2 rst_n = 1'b1;
        serve(W_NOP, 2, 32'h0);
        accept(2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        chk32("mid_retired", retired, 32'd1);

        // Instance B: address wrap past 0xFFFF_FFFC and 2-bit counter wrap
        @(negedge clk);
        b_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (b_req) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) timeout("b_req");
            chk32("b_addr", b_addr, b_exp_addr[k]);
            @(posedge clk); #1 b_rvalid = 1'b1; b_rdata = 32'h0000_0020 + 32'(k);
            @(posedge clk); #1 b_rvalid = 1'b0;
            chk1("b_valid", b_valid, 1'b1);
            chk32("b_pc", b_pc, b_exp_addr[k]);
            chk32("b_pc_plus4", b_pc_plus4, b_exp_addr[k] + 32'd4);
            if (k == 0) begin
                @(posedge clk); #1 b_rvalid = 1'b1; b_rdata = 32'hCAFE_F00D;
                @(posedge clk); #1 b_rvalid = 1'b0;
                chk32("b_spurious", b_instr, 32'h0000_0020);
            end
            @(posedge clk); #1 b_ready = 1'b1;
            @(posedge clk); #1 b_ready = 1'b0;
            chk32("b_retired", 32'(b_retired), 32'(b_exp_ret[k]));
            chk1("b_err", b_err, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
